xc_malu_seq: RTL

- Sequencer and state register stage for the multi-cycle MALU.
- Accepts an operation from the issue side and holds the iteration state: count, 64-bit accumulator and two 32-bit argument registers.
- Each cycle it presents that state to the muldivrem datapath and writes back the datapath's next-state values.
- Captures the 64-bit result when the datapath signals ready, then holds it under a valid/ready handshake until the consumer takes it.

---
 rtl/xc_malu_seq_if.sv | 52 +++++
 rtl/xc_malu_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/xc_malu_seq_if.sv
// ---------------------------------------------------------------------------
// xc_malu_seq_if : issue, datapath and result bus of the MALU sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface xc_malu_seq_if #(
  parameter int CW = 6
);
  // Issue side
  logic          valid;
  logic          in_ready;
  logic          flush;
  logic [31:0]   rs1;
  logic [31:0]   rs2;
  // Datapath side
  logic [CW-1:0] count;
  logic [63:0]   acc;
  logic [31:0]   arg_0;
  logic [31:0]   arg_1;
  logic          dp_valid;
  logic [63:0]   n_acc;
  logic [31:0]   n_arg_0;
  logic [31:0]   n_arg_1;
  logic          dp_ready;
  logic [63:0]   dp_result;
  // Result side
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   result;
  logic          err;

  // The sequencer itself
  modport slave (
    input  valid, flush, rs1, rs2,
    input  n_acc, n_arg_0, n_arg_1, dp_ready, dp_result,
    input  out_ready,
    output in_ready, count, acc, arg_0, arg_1, dp_valid,
    output out_valid, result, err
  );

  // Issue logic, datapath and consumer around the sequencer
  modport master (
    output valid, flush, rs1, rs2,
    output n_acc, n_arg_0, n_arg_1, dp_ready, dp_result,
    output out_ready,
    input  in_ready, count, acc, arg_0, arg_1, dp_valid,
    input  out_valid, result, err
  );
endinterface

`default_nettype wire

// File: rtl/xc_malu_seq.sv
// ---------------------------------------------------------------------------
// xc_malu_seq : MALU sequencer, iteration state register and result holder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xc_malu_seq #(
  parameter int CW        = 6,
  parameter int MAX_STEPS = 40
) (
  input  wire           clock,
  input  wire           reset,
  xc_malu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST_STEP = CW'(MAX_STEPS - 1);

  state_t        state_q,  state_d;
  logic [CW-1:0] count_q,  count_d;
  logic [63:0]   acc_q,    acc_d;
  logic [31:0]   arg_0_q,  arg_0_d;
  logic [31:0]   arg_1_q,  arg_1_d;
  logic [63:0]   result_q, result_d;
  logic          err_q,    err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      arg_0_q  <= '0;
      arg_1_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      arg_0_q  <= arg_0_d;
      arg_1_q  <= arg_1_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    arg_0_d  = arg_0_q;
    arg_1_d  = arg_1_q;
    result_d = result_q;
    err_d    = err_q;

    if (bus.flush) begin
      // Abandon everything; a coincident accept or completion is dropped
      state_d = S_IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.valid) begin
            acc_d   = '0;
            arg_0_d = bus.rs1;
            arg_1_d = bus.rs2;
            count_d = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          acc_d   = bus.n_acc;
          arg_0_d = bus.n_arg_0;
          arg_1_d = bus.n_arg_1;
          count_d = count_q + 1'b1;
          // Completion on the last allowed step beats the abort
          if (bus.dp_ready) begin
            result_d = bus.dp_result;
            err_d    = 1'b0;
            state_d  = S_DONE;
          end else if (count_q == C_LAST_STEP) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.dp_valid  = (state_q == S_RUN);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.count     = count_q;
  assign bus.acc       = acc_q;
  assign bus.arg_0     = arg_0_q;
  assign bus.arg_1     = arg_1_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire
